rv_mc_ctrl: RTL
===============

Name: rv_mc_ctrl

Overview:
Main control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and unified memory port. Drives the 2-bit aluop consumed by the ALU decoder, plus all mux selects and write enables. Sits beside the ALU decoder in the controller; the datapath registers (PC, oldPC, IR, ALUOut, Data) are owned by the datapath.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); kept as a parameter for bring-up only.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0], valid from DECODE onward
zero  in  1  ALU zero flag, sampled combinationally in BRANCH
mem_ready  in  1  memory access complete (used only with MEM_HANDSHAKE_EN)
pc_write  out  1  PC register enable (pc_update | (branch & zero))
adr_src  out  1  memory address: 0 PC, 1 ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR and oldPC load enable
result_src  out  2  00 ALUOut, 01 Data, 10 ALU result
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 data
alu_src_b  out  2  00 rs2 data, 01 immediate, 10 constant 4
aluop  out  2  to ALU decoder: 00 add, 01 fixed, 10 funct/opcode-decoded
reg_write  out  1  register file write enable
illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH; illegal=0. All outputs are Moore decodes of state, plus pc_write, which also depends on zero in BRANCH.
- Unlisted outputs are 0 in every state; alu_src_a/alu_src_b/result_src/aluop default to 00.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10, pc_write=1 -> DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, aluop=00 (branch/jal target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0010111 -> AUIPC
  - any other -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, aluop=00. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00 -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, aluop=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, aluop=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, aluop=10, result_src=00, branch=1. pc_write=zero (PC <- ALUOut target) -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1 (PC <- target in ALUOut) -> ALUWB (rd <- oldPC+4).
- AUIPC: alu_src_a=01, alu_src_b=01, aluop=10 -> ALUWB.
- TRAP: illegal=1 and held. All enables 0; remain in TRAP until rst_n asserted.
- Cycles per instruction without handshake:
  - lw 5
  - sw, R, I, jal, auipc 4
  - branch 3
- Reset mid-instruction: immediate return to FETCH; no partial writes after rst_n deasserts.
- State encoding: 4 bits, binary. Unused encodings -> FETCH on the next edge.

Optional Feature:
MEM_HANDSHAKE_EN
- Defined: FETCH, MEMREAD and MEMWRITE hold state while mem_ready=0. Strobes stay asserted during the hold: ir_write/pc_write in FETCH, mem_write in MEMWRITE. The transition occurs on the edge where mem_ready=1.
- Undefined: mem_ready is ignored and memory is single-cycle.

Test Plan:
- rst_n pulsed low mid-MEMADR -> state=FETCH asynchronously, all enables 0, illegal=0. First edge after release asserts ir_write=1, pc_write=1.
- lw (opcode 0000011) -> 5 cycles. aluop=00 in MEMADR; adr_src=1 in MEMREAD; reg_write=1 with result_src=01 only in cycle 5.
- add (0110011) then addi (0010011) -> aluop=10 in the execute cycle; alu_src_b=00 then 01; reg_write=1 in cycle 4 of each.
- beq (1100011) with zero=1 -> pc_write=1 in cycle 3. With zero=0 -> pc_write=0. Both 3 cycles, reg_write never asserted.
- opcode 1111111 -> DECODE->TRAP, illegal=1 and held for 20 cycles, mem_write/reg_write/pc_write stay 0 until reset.
- MEM_HANDSHAKE_EN with mem_ready low 3 cycles during sw -> stays in MEMWRITE with mem_write=1 for 4 cycles. Returns to FETCH on the edge with mem_ready=1.

Source files
------------

// File: rtl/rv_mc_ctrl.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/mem/writeback and drives datapath selects.
// Optional MEM_HANDSHAKE_EN: FETCH/MEMREAD/MEMWRITE stall on mem_ready; undefined means single-cycle memory.
module rv_mc_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_write,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    AUIPC    = 4'd11,
    TRAP     = 4'd12
  } state_t;

  state_t state, state_nxt;
  logic   mem_ok;
  logic   pc_update, branch, ir_en, mem_en, reg_en;
  logic   illegal_q;

`ifdef MEM_HANDSHAKE_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= illegal_q | (state_nxt == TRAP);
    end
  end

  always_comb begin
    state_nxt  = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    mem_en     = 1'b0;
    reg_en     = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    case (state)
      FETCH: begin
        ir_en      = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_nxt  = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        // Precompute branch/jal target into ALUOut while the opcode is decoded
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: state_nxt = MEMADR;
          7'b0110011:             state_nxt = EXECR;
          7'b0010011:             state_nxt = EXECI;
          7'b1100011:             state_nxt = BRANCH;
          7'b1101111:             state_nxt = JAL;
          7'b0010111:             state_nxt = AUIPC;
          default:                state_nxt = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = mem_ok ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_en     = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_en    = 1'b1;
        state_nxt = mem_ok ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        aluop     = 2'b10;
        state_nxt = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = 2'b10;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        reg_en = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        aluop     = 2'b10;
        branch    = 1'b1;
      end
      JAL: begin
        // PC takes the target already in ALUOut; ALU forms oldPC+4 for the link
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_nxt = ALUWB;
      end
      AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        aluop     = 2'b10;
        state_nxt = ALUWB;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Enables are forced low while reset is held so nothing is written mid-reset
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_en;
  assign mem_write = rst_n & mem_en;
  assign reg_write = rst_n & reg_en;
  assign illegal   = illegal_q;

endmodule
